mips_multi_control: RTL and testbench

Multicycle MIPS control unit that sequences the existing `data_path` through fetch, decode, execute, memory and writeback. It replaces hand-driven control stimulus with a Moore FSM plus branch-qualified PC enable. It adds three things to the datapath control set:

- optional memory wait states via a `mem_ready` handshake;
- jump and `addi` support;
- an illegal-opcode flag and a retired-instruction counter for bring-up.

---
 rtl/mips_ctrl_pkg.sv | 50 +++++
 rtl/mips_multi_control_alu_decoder.sv | 24 ++
 rtl/mips_multi_control.sv | 143 ++++++++++++++
 tb/tb_mips_multi_control.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, funct and control encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCA_PC  = 2'b00;
    localparam logic [1:0] SRCA_REG = 2'b01;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mips_multi_control_alu_decoder.sv
// alu_decoder: maps the R-type funct field to an ALU operation and flags unsupported functs
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       legal
);

    // funct lookup; anything unlisted falls back to add and is reported illegal
    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multi_control.sv
// mips_multi_control: Moore FSM sequencing the multicycle MIPS datapath with wait states, retire counter and illegal flag
module mips_multi_control
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b0,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       Funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    state_t     state_q, state_d;
    logic       mr, retire, bad;
    logic [2:0] funct_alu;
    logic       funct_legal;

    assign mr    = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state = state_q;

    alu_decoder u_dec (
        .funct       (Funct),
        .alu_control (funct_alu),
        .legal       (funct_legal)
    );

    // state register, retire counter and registered illegal pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            retired <= retired + CNT_W'(retire);
            illegal <= bad;
        end
    end

    // next state; a decode that falls back to FETCH is an illegal instruction
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = mr ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = funct_legal ? EXECUTE : FETCH;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = mr ? MEMWB : MEMRD;
            MEMWR:   state_d = mr ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
        bad    = (state_q == DECODE) && (state_d == FETCH);
        retire = (state_d == FETCH) && (state_q inside {MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP});
    end

    // Moore output decode; reset shows the FETCH decode with its strobes suppressed
    always_comb begin
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = PC_ALU;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_REG;
        ALUControl = ALU_ADD;
        case (reset ? FETCH : state_q)
            FETCH: begin
                IRWrite = mr;
                PCWrite = mr;
                ALUSrcB = SRCB_FOUR;
            end
            DECODE:  ALUSrcB = SRCB_IMM_SH;
            MEMADR, ADDIEX: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            MEMRD:   IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = mr;
            end
            EXECUTE: begin
                ALUSrcA    = SRCA_REG;
                ALUControl = funct_alu;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = SRCA_REG;
                ALUControl = ALU_SUB;
                PCSrc      = PC_ALUOUT;
                PCWrite    = zero;
            end
            ADDIWB:  RegWrite = 1'b1;
            JUMP: begin
                PCSrc   = PC_JUMP;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            IRWrite = 1'b0;
            PCWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multi_control.sv
// tb_mips_multi_control: directed scoreboard bench for the multicycle MIPS controller
module tb_mips_multi_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
    logic [5:0] op = OP_J, Funct = FN_ADD;

    logic       mw, iord, irw, rw, m2r, rd, pcw, ill;
    logic [1:0] pcs, sa, sbv;
    logic [2:0] ac;
    logic [3:0] ret, st;
    logic [15:0] ctl;

    logic        n_mw, n_iord, n_irw, n_rw, n_m2r, n_rd, n_pcw, n_ill;
    logic [1:0]  n_pcs, n_sa, n_sb;
    logic [2:0]  n_ac;
    logic [31:0] n_ret;
    logic [3:0]  n_st;

    assign ctl = {mw, iord, irw, rw, m2r, rd, pcw, pcs, sa, sbv, ac};

    mips_multi_control #(.MEM_WAIT_EN(1'b1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .Funct(Funct), .zero(zero), .mem_ready(mem_ready),
        .MemWrite(mw), .IorD(iord), .IRWrite(irw), .RegWrite(rw), .MemtoReg(m2r), .RegDst(rd),
        .PCWrite(pcw), .PCSrc(pcs), .ALUSrcA(sa), .ALUSrcB(sbv), .ALUControl(ac),
        .illegal(ill), .retired(ret), .state(st)
    );

    mips_multi_control dut0 (
        .clk(clk), .reset(reset), .op(op), .Funct(Funct), .zero(zero), .mem_ready(mem_ready),
        .MemWrite(n_mw), .IorD(n_iord), .IRWrite(n_irw), .RegWrite(n_rw), .MemtoReg(n_m2r), .RegDst(n_rd),
        .PCWrite(n_pcw), .PCSrc(n_pcs), .ALUSrcA(n_sa), .ALUSrcB(n_sb), .ALUControl(n_ac),
        .illegal(n_ill), .retired(n_ret), .state(n_st)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
        logic [3:0]  ret;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0, fails = 0, r = 0;
    logic [2:0] exp_alu = ALU_ADD;

    // expected control word {MemWrite,IorD,IRWrite,RegWrite,MemtoReg,RegDst,PCWrite,PCSrc,ALUSrcA,ALUSrcB,ALUControl}
    function automatic logic [15:0] ctl_of(state_t s, logic m, logic z, logic [2:0] alu, logic rst);
        logic f_mw, f_iord, f_irw, f_rw, f_m2r, f_rd, f_pcw;
        logic [1:0] f_pcs, f_sa, f_sb;
        logic [2:0] f_ac;
        {f_mw, f_iord, f_irw, f_rw, f_m2r, f_rd, f_pcw} = 7'b0;
        f_pcs = 2'b00; f_sa = 2'b00; f_sb = 2'b00; f_ac = 3'b000;
        case (rst ? FETCH : s)
            FETCH:   begin f_irw = m; f_pcw = m; f_sb = 2'b01; end
            DECODE:  f_sb = 2'b11;
            MEMADR:  begin f_sa = 2'b01; f_sb = 2'b10; end
            MEMRD:   f_iord = 1'b1;
            MEMWB:   begin f_m2r = 1'b1; f_rw = 1'b1; end
            MEMWR:   begin f_iord = 1'b1; f_mw = m; end
            EXECUTE: begin f_sa = 2'b01; f_ac = alu; end
            ALUWB:   begin f_rd = 1'b1; f_rw = 1'b1; end
            BRANCH:  begin f_sa = 2'b01; f_ac = 3'b001; f_pcs = 2'b01; f_pcw = z; end
            ADDIEX:  begin f_sa = 2'b01; f_sb = 2'b10; end
            ADDIWB:  f_rw = 1'b1;
            JUMP:    begin f_pcs = 2'b10; f_pcw = 1'b1; end
            default: ;
        endcase
        if (rst) begin f_irw = 1'b0; f_pcw = 1'b0; end
        return {f_mw, f_iord, f_irw, f_rw, f_m2r, f_rd, f_pcw, f_pcs, f_sa, f_sb, f_ac};
    endfunction

    task automatic step(input state_t s, input logic m, input logic i, input string tag);
        exp_t e;
        mem_ready = m;
        e.st  = s;
        e.ctl = ctl_of(s, m, zero, exp_alu, reset);
        e.ill = i;
        e.ret = 4'(r);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        assert (st === e.st) else begin fails++; $error("FAIL %s state got %0d want %0d", tag, st, e.st); end
        checks++;
        assert (ctl === e.ctl) else begin fails++; $error("FAIL %s ctl got %b want %b", tag, ctl, e.ctl); end
        checks++;
        assert (ill === e.ill) else begin fails++; $error("FAIL %s illegal got %b want %b", tag, ill, e.ill); end
        checks++;
        assert (ret === e.ret) else begin fails++; $error("FAIL %s retired got %0d want %0d", tag, ret, e.ret); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(FETCH, 1, 0, "reset");
        reset = 1'b0;
        // lw with 2 fetch and 3 memory wait cycles: 10 cycles
        op = OP_LW;
        mem_ready = 1'b0;
        #1;
        checks++;
        assert (n_irw === 1'b1) else begin fails++; $error("FAIL nowait_irwrite got %b want 1", n_irw); end
        step(FETCH, 0, 0, "lw_f0");
        checks++;
        assert (n_st === 4'(DECODE)) else begin fails++; $error("FAIL nowait_state got %0d want %0d", n_st, DECODE); end
        step(FETCH, 0, 0, "lw_f1");
        step(FETCH, 1, 0, "lw_f2");
        step(DECODE, 1, 0, "lw_dec");
        step(MEMADR, 1, 0, "lw_adr");
        step(MEMRD, 0, 0, "lw_rd0");
        step(MEMRD, 0, 0, "lw_rd1");
        step(MEMRD, 0, 0, "lw_rd2");
        step(MEMRD, 1, 0, "lw_rd3");
        step(MEMWB, 1, 0, "lw_wb");
        r = 1;
        // second lw abandoned by reset in MEMRD
        step(FETCH, 1, 0, "lw2_f");
        step(DECODE, 1, 0, "lw2_dec");
        step(MEMADR, 1, 0, "lw2_adr");
        reset = 1'b1;
        step(MEMRD, 1, 0, "rst_mid");
        reset = 1'b0;
        r = 0;
        // sw with one memory wait
        op = OP_SW;
        step(FETCH, 1, 0, "sw_f");
        step(DECODE, 1, 0, "sw_dec");
        step(MEMADR, 1, 0, "sw_adr");
        step(MEMWR, 0, 0, "sw_wr0");
        step(MEMWR, 1, 0, "sw_wr1");
        r++;
        // R-type sub, slt, or
        op = OP_RTYPE;
        Funct = FN_SUB; exp_alu = ALU_SUB;
        step(FETCH, 1, 0, "sub_f"); step(DECODE, 1, 0, "sub_dec"); step(EXECUTE, 1, 0, "sub_ex"); step(ALUWB, 1, 0, "sub_wb");
        r++;
        Funct = FN_SLT; exp_alu = ALU_SLT;
        step(FETCH, 1, 0, "slt_f"); step(DECODE, 1, 0, "slt_dec"); step(EXECUTE, 1, 0, "slt_ex"); step(ALUWB, 1, 0, "slt_wb");
        r++;
        Funct = FN_OR; exp_alu = ALU_OR;
        step(FETCH, 1, 0, "or_f"); step(DECODE, 1, 0, "or_dec"); step(EXECUTE, 1, 0, "or_ex"); step(ALUWB, 1, 0, "or_wb");
        r++;
        // addi
        op = OP_ADDI;
        step(FETCH, 1, 0, "addi_f"); step(DECODE, 1, 0, "addi_dec"); step(ADDIEX, 1, 0, "addi_ex"); step(ADDIWB, 1, 0, "addi_wb");
        r++;
        // beq taken then not taken
        op = OP_BEQ;
        zero = 1'b1;
        step(FETCH, 1, 0, "beq1_f"); step(DECODE, 1, 0, "beq1_dec"); step(BRANCH, 1, 0, "beq1_br");
        r++;
        zero = 1'b0;
        step(FETCH, 1, 0, "beq0_f"); step(DECODE, 1, 0, "beq0_dec"); step(BRANCH, 1, 0, "beq0_br");
        r++;
        // illegal opcode, then a j
        op = 6'b111111;
        step(FETCH, 1, 0, "ilop_f"); step(DECODE, 1, 0, "ilop_dec");
        op = OP_J;
        step(FETCH, 1, 1, "ilop_flag"); step(DECODE, 1, 0, "j1_dec"); step(JUMP, 1, 0, "j1_jmp");
        r++;
        // illegal funct, then a j
        op = OP_RTYPE;
        Funct = 6'b000111;
        step(FETCH, 1, 0, "ilfn_f"); step(DECODE, 1, 0, "ilfn_dec");
        op = OP_J;
        step(FETCH, 1, 1, "ilfn_flag"); step(DECODE, 1, 0, "j2_dec"); step(JUMP, 1, 0, "j2_jmp");
        r++;
        // 17 jumps wrap the 4-bit counter to 1
        reset = 1'b1;
        step(FETCH, 1, 0, "rst2");
        reset = 1'b0;
        r = 0;
        for (int k = 0; k < 17; k++) begin
            step(FETCH, 1, 0, "jw_f"); step(DECODE, 1, 0, "jw_dec"); step(JUMP, 1, 0, "jw_jmp");
            r++;
        end
        step(FETCH, 1, 0, "wrap");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
